note_tone_gen: RTL and testbench

Tone generator on the receive side of the music player's note-transfer interface. It consumes the note strobe (`tran_vld`), the 6-bit note code from the music ROM, the stop strobe (`tran_end`) and the 10-bit volume, and drives a PWM square wave onto the buzzer pin. It sits between the player controller and the top-level buzzer output. It owns note decode, pitch division, volume-to-duty scaling and inter-note articulation.

---
 rtl/note_tone_gen.sv | 129 ++++++++++++
 tb/tb_note_tone_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_gen.sv
// note_tone_gen: note decode, pitch divider and volume-scaled PWM buzzer drive.
// Each accepted note is preceded by a short silent articulation gap.
module note_tone_gen #(
  parameter int GAP_CYC = 50_000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       tran_vld,
  input  logic       tran_end,
  input  logic [5:0] q,
  input  logic [9:0] volume_in,
  output logic       beep,
  output logic       playing,
  output logic [5:0] note_cur
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GAP  = 3'b010,
    PLAY = 3'b100
  } state_t;

  localparam logic [19:0] GAP_LAST = 20'(GAP_CYC - 1);

  state_t      state, state_nx;
  logic [19:0] gap_cnt;
  logic [18:0] cnt;
  logic [18:0] period;
  logic        rest;
  logic [9:0]  vol_r;
  logic [9:0]  vol_eff;
  logic [28:0] prod;
  logic [18:0] high_time;
  logic [18:0] lut_base;
  logic [18:0] lut_period;
  logic        lut_rest;
  logic        accept;
  logic        gap_done;

  assign accept   = tran_vld & ~tran_end;
  assign gap_done = state[1] & (gap_cnt == GAP_LAST);

  // Volume is sampled at period start; bypass so the new value counts at once.
  assign vol_eff   = (cnt == '0) ? volume_in : vol_r;
  assign prod      = {10'b0, period} * {19'b0, vol_eff};
  assign high_time = 19'(prod >> 11);

  always_comb begin
    lut_base = '0;
    case (q[3:0])
      4'd0:    lut_base = 19'd191113;
      4'd1:    lut_base = 19'd180386;
      4'd2:    lut_base = 19'd170262;
      4'd3:    lut_base = 19'd160706;
      4'd4:    lut_base = 19'd151686;
      4'd5:    lut_base = 19'd143173;
      4'd6:    lut_base = 19'd135137;
      4'd7:    lut_base = 19'd127551;
      4'd8:    lut_base = 19'd120394;
      4'd9:    lut_base = 19'd113636;
      4'd10:   lut_base = 19'd107258;
      4'd11:   lut_base = 19'd101238;
      default: lut_base = '0;
    endcase
  end

  always_comb begin
    lut_period = lut_base;
    case (q[5:4])
      2'd0:    lut_period = lut_base << 1;
      2'd2:    lut_period = lut_base >> 1;
      default: lut_period = lut_base;
    endcase
    lut_rest = (q[5:4] == 2'd3) | (q[3:0] >= 4'd12);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[0]: state_nx = IDLE;
      state[1]: if (gap_done) state_nx = PLAY;
      state[2]: state_nx = PLAY;
      default:  state_nx = IDLE;
    endcase
    if (accept)   state_nx = GAP;
    if (tran_end) state_nx = IDLE;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      beep     <= 1'b0;
      playing  <= 1'b0;
      note_cur <= '0;
      period   <= '0;
      rest     <= 1'b1;
      vol_r    <= '0;
      gap_cnt  <= '0;
      cnt      <= '0;
    end else begin
      playing <= state_nx[1] | state_nx[2];
      if (cnt == '0) vol_r <= volume_in;
      if (tran_end) begin
        gap_cnt <= '0;
        cnt     <= '0;
        beep    <= 1'b0;
      end else if (accept) begin
        note_cur <= q;
        period   <= lut_period;
        rest     <= lut_rest;
        gap_cnt  <= '0;
        cnt      <= '0;
        beep     <= 1'b0;
      end else begin
        gap_cnt <= (state[1] && !gap_done) ? gap_cnt + 20'd1 : '0;
        if (state[2])
          cnt <= (cnt == period - 19'd1) ? '0 : cnt + 19'd1;
        else
          cnt <= '0;
        beep <= state[2] & (cnt < high_time) & ~rest;
      end
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed bench with a pulse-width/period scoreboard.
// Expected pulse lengths are queued by stimulus and popped by the monitor.
module tb_note_tone_gen;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tran_vld = 1'b0;
  logic       tran_end = 1'b0;
  logic [5:0] q = '0;
  logic [9:0] volume_in = '0;
  logic       beep;
  logic       playing;
  logic [5:0] note_cur;

  int    checks = 0;
  int    failures = 0;
  longint cyc = 0;
  int    exp_high[$];
  int    exp_per[$];
  bit    mon_en = 1'b0;

  note_tone_gen #(.GAP_CYC(10)) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .tran_vld(tran_vld),
    .tran_end(tran_end),
    .q(q),
    .volume_in(volume_in),
    .beep(beep),
    .playing(playing),
    .note_cur(note_cur)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [5:0] c);
    @(negedge sysclk);
    q = c;
    tran_vld = 1'b1;
    @(negedge sysclk);
    tran_vld = 1'b0;
  endtask

  task automatic stop();
    @(negedge sysclk);
    tran_end = 1'b1;
    @(negedge sysclk);
    tran_end = 1'b0;
  endtask

  task automatic wait_beep(input logic v, input int lim, input string name);
    int n = 0;
    while (beep !== v && n < lim) begin
      @(negedge sysclk);
      n++;
    end
    chk(name, 32'(beep), 32'(v));
  endtask

  task automatic quiet(input int n, input logic play_exp, input string name);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      if (beep !== 1'b0 || playing !== play_exp) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  // Monitor: measures each beep pulse and compares against the queues.
  initial begin
    bit     prev = 1'b0;
    bit     have_rise = 1'b0;
    longint rise_cyc = 0;
    forever begin
      @(negedge sysclk);
      if (!mon_en) begin
        have_rise = 1'b0;
        prev = beep;
      end else begin
        if (beep && !prev) begin
          if (have_rise) begin
            if (exp_per.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_period: got %0d expected none", cyc - rise_cyc);
            end else begin
              chk("sb_period", 32'(cyc - rise_cyc), 32'(exp_per.pop_front()));
            end
          end
          rise_cyc = cyc;
          have_rise = 1'b1;
        end else if (!beep && prev && have_rise) begin
          if (exp_high.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_high: got %0d expected none", cyc - rise_cyc);
          end else begin
            chk("sb_high", 32'(cyc - rise_cyc), 32'(exp_high.pop_front()));
          end
        end
        prev = beep;
      end
    end
  end

  initial begin
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge sysclk);
        if (beep !== 1'b0 || playing !== 1'b0 || note_cur !== 6'd0) bad++;
      end
      chk("reset_idle", 32'(bad), 32'd0);
    end

    // Mid A, full volume: timing of playing and first beep
    volume_in = 10'd1023;
    send(6'b011001);
    chk("midA_playing_c1", 32'(playing), 32'd1);
    chk("midA_note_cur", 32'(note_cur), 32'(6'b011001));
    chk("midA_period", 32'(dut.period), 32'd113636);
    repeat (10) @(negedge sysclk);
    chk("midA_beep_c11", 32'(beep), 32'd0);
    @(negedge sysclk);
    chk("midA_beep_c12", 32'(beep), 32'd1);
    chk("midA_high_time", 32'(dut.high_time), 32'd56762);

    // tran_vld and tran_end together: end wins
    @(negedge sysclk);
    q = 6'b101001;
    tran_vld = 1'b1;
    tran_end = 1'b1;
    @(negedge sysclk);
    tran_vld = 1'b0;
    tran_end = 1'b0;
    chk("both_playing", 32'(playing), 32'd0);
    chk("both_beep", 32'(beep), 32'd0);
    chk("both_note_cur", 32'(note_cur), 32'(6'b011001));

    // Back-to-back notes: low A then high A, last wins
    @(negedge sysclk);
    q = 6'b001001;
    tran_vld = 1'b1;
    @(negedge sysclk);
    chk("lowA_period", 32'(dut.period), 32'd227272);
    q = 6'b101001;
    @(negedge sysclk);
    tran_vld = 1'b0;
    chk("b2b_note_cur", 32'(note_cur), 32'(6'b101001));
    chk("highA_period", 32'(dut.period), 32'd56818);
    repeat (10) @(negedge sysclk);
    chk("highA_beep_c11", 32'(beep), 32'd0);
    @(negedge sysclk);
    chk("highA_beep_c12", 32'(beep), 32'd1);
    chk("highA_high_time", 32'(dut.high_time), 32'd28381);
    stop();
    chk("end_beep", 32'(beep), 32'd0);
    chk("end_playing", 32'(playing), 32'd0);

    // Rest notes: end-of-song marker and semitone 12
    send(6'b111000);
    chk("rest_eos_note", 32'(note_cur), 32'(6'b111000));
    quiet(2000, 1'b1, "rest_eos_quiet");
    send(6'b011100);
    chk("rest_mid_note", 32'(note_cur), 32'(6'b011100));
    quiet(2000, 1'b1, "rest_mid_quiet");
    stop();

    // Zero volume
    volume_in = 10'd0;
    send(6'b011001);
    quiet(2000, 1'b1, "vol0_quiet");
    chk("vol0_high_time", 32'(dut.high_time), 32'd0);
    stop();

    // Asynchronous reset while beep is high
    volume_in = 10'd1023;
    send(6'b011001);
    repeat (11) @(negedge sysclk);
    chk("pre_reset_beep", 32'(beep), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_beep", 32'(beep), 32'd0);
    chk("async_reset_playing", 32'(playing), 32'd0);
    chk("async_reset_note", 32'(note_cur), 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    quiet(50, 1'b0, "post_reset_idle");

    // High B: volume drop mid-period applies from next period
    exp_high.push_back(25284);
    exp_per.push_back(50619);
    exp_high.push_back(12654);
    mon_en = 1'b1;
    send(6'b101011);
    wait_beep(1'b1, 20, "volB_rise1");
    repeat (5000) @(negedge sysclk);
    volume_in = 10'd512;
    wait_beep(1'b0, 30000, "volB_fall1");
    wait_beep(1'b1, 30000, "volB_rise2");
    wait_beep(1'b0, 20000, "volB_fall2");
    repeat (3) @(negedge sysclk);
    mon_en = 1'b0;
    chk("sb_high_left", 32'(exp_high.size()), 32'd0);
    chk("sb_per_left", 32'(exp_per.size()), 32'd0);
    stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
